// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the parameterised FIFO:
//   - fifo_mode_e : read-side behaviour (registered read or first-word-fall-through)
//   - ptr_width() : pointer width for a given depth (address bits plus a wrap bit)
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // The extra MSB tells full (same address, different lap) apart from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr
//   One FIFO pointer: an enabled incrementer whose MSB is the wrap bit.
//   Because the depth is a power of two, a plain binary increment makes the
//   address bits roll over from DEPTH-1 to 0 and toggles the wrap bit at the
//   same time.
// Ports
//   clk_in   : clock, rising edge
//   areset_b : asynchronous active-low reset, clears the pointer to zero
//   inc_en   : advance the pointer by one on this edge
//   ptr      : full pointer, wrap bit included
//   addr     : storage address (pointer without the wrap bit)
//   wrap     : wrap bit
module fifo_ptr #(
  parameter int PW = 4
) (
  input  logic          clk_in,
  input  logic          areset_b,
  input  logic          inc_en,
  output logic [PW-1:0] ptr,
  output logic [PW-2:0] addr,
  output logic          wrap
);

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      ptr <= '0;
    end else if (inc_en) begin
      ptr <= ptr + PW'(1);
    end
  end

  assign addr = ptr[PW-2:0];
  assign wrap = ptr[PW-1];

endmodule

// File: rtl/fifo_mem_param.sv
// fifo_mem_param
//   Single-clock synchronous FIFO with configurable width, depth and read mode.
//   Occupancy is derived from the difference of two wrap-bit pointers, so all
//   level flags are combinational from registered state.
// Parameters
//   DATA_WIDTH : bits per entry
//   DEPTH      : entry count, power of two, >= 2
//   FWFT       : 0 = registered read (data the cycle after the pop),
//                1 = first-word-fall-through (head visible, rd_ready acknowledges)
//   AFULL_THR  : afull_ind when count >= AFULL_THR
//   AEMPTY_THR : aempty_ind when count <= AEMPTY_THR
// Ports
//   clk_in, areset_b          : clock (rising edge), async active-low reset
//   wr_valid, wr_ready, wr_data : push side; wr_ready is simply "not full"
//   rd_ready, rd_valid, rd_data : pop side
//   count                     : occupancy, 0..DEPTH
//   full_ind, empty_ind, afull_ind, aempty_ind : level flags
//   overflow_ind, underflow_ind : sticky error flags, cleared by err_clr
//   err_clr                   : clears the sticky flags (a same-cycle set wins)
module fifo_mem_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int FWFT       = 0,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                          clk_in,
  input  logic                          areset_b,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ptr_width(DEPTH)-1:0]   count,
  output logic                          full_ind,
  output logic                          empty_ind,
  output logic                          afull_ind,
  output logic                          aempty_ind,
  output logic                          overflow_ind,
  output logic                          underflow_ind,
  input  logic                          err_clr
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THR);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THR);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  logic                  wr_wrap;
  logic                  rd_wrap;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Occupancy: modular difference of the pointers; the wrap bit makes
  // count == DEPTH distinguishable from count == 0.
  assign count      = wr_ptr - rd_ptr;
  assign full_ind   = (count == DEPTH_C);
  assign empty_ind  = (count == '0);
  assign afull_ind  = (count >= AFULL_C);
  assign aempty_ind = (count <= AEMPTY_C);
  assign wr_ready   = !full_ind;

  // A full FIFO refuses the push even if a pop happens in the same cycle;
  // an empty FIFO ignores the pop, so a simultaneous request is push-only.
  // In both read modes a pop is a request/acknowledge against a non-empty FIFO.
  assign push = wr_valid && !full_ind;
  assign pop  = rd_ready && !empty_ind;

  fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk_in   (clk_in),
    .areset_b (areset_b),
    .inc_en   (push),
    .ptr      (wr_ptr),
    .addr     (wr_addr),
    .wrap     (wr_wrap)
  );

  fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk_in   (clk_in),
    .areset_b (areset_b),
    .inc_en   (pop),
    .ptr      (rd_ptr),
    .addr     (rd_addr),
    .wrap     (rd_wrap)
  );

  // Storage is deliberately left unreset; clearing the pointers is enough
  // to discard its contents.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr stays set.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      overflow_ind  <= 1'b0;
      underflow_ind <= 1'b0;
    end else begin
      if (wr_valid && full_ind) begin
        overflow_ind <= 1'b1;
      end else if (err_clr) begin
        overflow_ind <= 1'b0;
      end
      if (rd_ready && empty_ind) begin
        underflow_ind <= 1'b1;
      end else if (err_clr) begin
        underflow_ind <= 1'b0;
      end
    end
  end

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head entry is presented continuously; rd_ready acts as acknowledge.
      assign rd_valid = !empty_ind;
      assign rd_data  = mem[rd_addr];
    end else begin : g_std
      // Registered read: data captured on the pop edge, valid for one cycle,
      // then held until the next pop.
      always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= pop;
          if (pop) begin
            rd_data <= mem[rd_addr];
          end
        end
      end
    end
  endgenerate

  // Wrap bits are part of the pointers already used for count; the separate
  // taps are kept for debug visibility only.
  logic unused_wrap;
  assign unused_wrap = wr_wrap ^ rd_wrap;

endmodule

// File: tb/tb_fifo_mem_param.sv
// tb_fifo_mem_param
//   Directed bench for fifo_mem_param. Two instances share clock and reset:
//   u_std (FWFT=0) and u_fwft (FWFT=1), both DEPTH=8, DATA_WIDTH=32.
module tb_fifo_mem_param;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic areset_b;

  logic        s_wr_valid, s_rd_ready, s_err_clr;
  logic [31:0] s_wr_data;
  logic        s_wr_ready, s_rd_valid;
  logic [31:0] s_rd_data;
  logic [3:0]  s_count;
  logic        s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;

  logic        f_wr_valid, f_rd_ready, f_err_clr;
  logic [31:0] f_wr_data;
  logic        f_wr_ready, f_rd_valid;
  logic [31:0] f_rd_data;
  logic [3:0]  f_count;
  logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_mem_param #(.DATA_WIDTH(32), .DEPTH(8), .FWFT(0)) u_std (
    .clk_in        (clk_in),
    .areset_b      (areset_b),
    .wr_valid      (s_wr_valid),
    .wr_ready      (s_wr_ready),
    .wr_data       (s_wr_data),
    .rd_ready      (s_rd_ready),
    .rd_valid      (s_rd_valid),
    .rd_data       (s_rd_data),
    .count         (s_count),
    .full_ind      (s_full),
    .empty_ind     (s_empty),
    .afull_ind     (s_afull),
    .aempty_ind    (s_aempty),
    .overflow_ind  (s_ovf),
    .underflow_ind (s_unf),
    .err_clr       (s_err_clr)
  );

  fifo_mem_param #(.DATA_WIDTH(32), .DEPTH(8), .FWFT(1)) u_fwft (
    .clk_in        (clk_in),
    .areset_b      (areset_b),
    .wr_valid      (f_wr_valid),
    .wr_ready      (f_wr_ready),
    .wr_data       (f_wr_data),
    .rd_ready      (f_rd_ready),
    .rd_valid      (f_rd_valid),
    .rd_data       (f_rd_data),
    .count         (f_count),
    .full_ind      (f_full),
    .empty_ind     (f_empty),
    .afull_ind     (f_afull),
    .aempty_ind    (f_aempty),
    .overflow_ind  (f_ovf),
    .underflow_ind (f_unf),
    .err_clr       (f_err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    areset_b   = 1'b0;
    s_wr_valid = 1'b0; s_rd_ready = 1'b0; s_err_clr = 1'b0; s_wr_data = '0;
    f_wr_valid = 1'b0; f_rd_ready = 1'b0; f_err_clr = 1'b0; f_wr_data = '0;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_count",   32'(s_count), 32'd0);
    chk("rst_empty",   32'(s_empty), 32'd1);
    chk("rst_full",    32'(s_full), 32'd0);
    chk("rst_aempty",  32'(s_aempty), 32'd1);
    chk("rst_afull",   32'(s_afull), 32'd0);
    chk("rst_wr_ready",32'(s_wr_ready), 32'd1);
    chk("rst_rd_valid",32'(s_rd_valid), 32'd0);
    chk("rst_rd_data", s_rd_data, 32'd0);
    chk("rst_ovf",     32'(s_ovf), 32'd0);
    chk("rst_unf",     32'(s_unf), 32'd0);
    chk("rst_f_valid", 32'(f_rd_valid), 32'd0);
    areset_b = 1'b1;

    // Underflow straight after reset
    s_rd_ready = 1'b1;
    tick();
    chk("unf_set",      32'(s_unf), 32'd1);
    chk("unf_rd_valid", 32'(s_rd_valid), 32'd0);
    chk("unf_rd_data",  s_rd_data, 32'd0);
    chk("unf_count",    32'(s_count), 32'd0);
    s_rd_ready = 1'b0;
    s_err_clr  = 1'b1;
    tick();
    chk("unf_clr", 32'(s_unf), 32'd0);
    s_err_clr = 1'b0;

    // Fill 0..7
    for (int i = 0; i < 8; i++) begin
      s_wr_valid = 1'b1;
      s_wr_data  = 32'(i);
      tick();
      chk("fill_count",  32'(s_count), 32'(i + 1));
      chk("fill_afull",  32'(s_afull), 32'((i + 1) >= 6));
      chk("fill_aempty", 32'(s_aempty), 32'((i + 1) <= 2));
      chk("fill_full",   32'(s_full), 32'((i + 1) == 8));
    end
    chk("full_wr_ready", 32'(s_wr_ready), 32'd0);

    // Overflow at full
    s_wr_data = 32'hDEAD;
    tick();
    chk("ovf_set",   32'(s_ovf), 32'd1);
    chk("ovf_count", 32'(s_count), 32'd8);
    s_wr_valid = 1'b0;
    tick();
    chk("ovf_sticky", 32'(s_ovf), 32'd1);
    s_wr_valid = 1'b1;
    s_err_clr  = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(s_ovf), 32'd1);
    s_wr_valid = 1'b0;
    tick();
    chk("ovf_clr", 32'(s_ovf), 32'd0);
    s_err_clr = 1'b0;

    // Drain; first pop coincides with a push that full must refuse
    for (int i = 0; i < 8; i++) begin
      s_wr_valid = (i == 0);
      s_wr_data  = 32'hBEEF;
      s_rd_ready = 1'b1;
      tick();
      chk("drain_data",  s_rd_data, 32'(i));
      chk("drain_valid", 32'(s_rd_valid), 32'd1);
      chk("drain_count", 32'(s_count), 32'(7 - i));
    end
    chk("drain_ovf", 32'(s_ovf), 32'd1);
    s_wr_valid = 1'b0;
    s_rd_ready = 1'b0;
    s_err_clr  = 1'b1;
    tick();
    chk("idle_valid", 32'(s_rd_valid), 32'd0);
    chk("idle_hold",  s_rd_data, 32'd7);
    chk("idle_empty", 32'(s_empty), 32'd1);
    chk("idle_ovf",   32'(s_ovf), 32'd0);
    s_err_clr = 1'b0;

    // Push and pop together while empty: push only
    s_wr_valid = 1'b1;
    s_wr_data  = 32'h100;
    s_rd_ready = 1'b1;
    tick();
    chk("emp_pp_count", 32'(s_count), 32'd1);
    chk("emp_pp_valid", 32'(s_rd_valid), 32'd0);
    chk("emp_pp_unf",   32'(s_unf), 32'd1);

    // 20 push/pop pairs across the pointer wrap
    for (int k = 0; k < 20; k++) begin
      s_wr_data = 32'h101 + 32'(k);
      s_err_clr = (k == 0);
      tick();
      chk("wrap_data",  s_rd_data, 32'h100 + 32'(k));
      chk("wrap_valid", 32'(s_rd_valid), 32'd1);
      chk("wrap_count", 32'(s_count), 32'd1);
    end
    s_err_clr  = 1'b0;
    chk("wrap_unf", 32'(s_unf), 32'd0);
    s_wr_valid = 1'b0;
    tick();
    chk("wrap_last",  s_rd_data, 32'h114);
    chk("wrap_empty", 32'(s_empty), 32'd1);
    s_rd_ready = 1'b0;

    // Reset mid-operation at count 5
    for (int i = 0; i < 5; i++) begin
      s_wr_valid = 1'b1;
      s_wr_data  = 32'h200 + 32'(i);
      tick();
    end
    s_wr_valid = 1'b0;
    chk("mid_count5", 32'(s_count), 32'd5);
    areset_b = 1'b0;
    #1;
    chk("mid_count",   32'(s_count), 32'd0);
    chk("mid_empty",   32'(s_empty), 32'd1);
    chk("mid_aempty",  32'(s_aempty), 32'd1);
    chk("mid_rd_data", s_rd_data, 32'd0);
    #2;
    areset_b = 1'b1;
    s_rd_ready = 1'b1;
    tick();
    chk("mid_unf",      32'(s_unf), 32'd1);
    chk("mid_rd_valid", 32'(s_rd_valid), 32'd0);
    s_rd_ready = 1'b0;

    // FWFT instance
    f_wr_valid = 1'b1;
    f_wr_data  = 32'hA5;
    tick();
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_data",  f_rd_data, 32'hA5);
    f_wr_valid = 1'b0;
    tick();
    chk("fwft_hold", f_rd_data, 32'hA5);
    f_wr_valid = 1'b1;
    f_wr_data  = 32'h5A;
    tick();
    chk("fwft_head2",  f_rd_data, 32'hA5);
    chk("fwft_count2", 32'(f_count), 32'd2);
    f_wr_valid = 1'b0;
    f_rd_ready = 1'b1;
    tick();
    chk("fwft_pop1", f_rd_data, 32'h5A);
    chk("fwft_cnt1", 32'(f_count), 32'd1);
    tick();
    chk("fwft_empty_valid", 32'(f_rd_valid), 32'd0);
    chk("fwft_empty", 32'(f_empty), 32'd1);
    tick();
    chk("fwft_unf", 32'(f_unf), 32'd1);
    f_rd_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
